// File: rtl/wb_gain_sched_pkg.sv
// ---------------------------------------------------------------------------
// wb_gain_sched_pkg : shared constants, FSM encoding and tag type (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package wb_gain_sched_pkg;

  localparam int AVG_W  = 8;
  localparam int SUM_W  = 10;
  localparam int DEN_W  = 10;
  localparam int QUOT_W = 18;

  localparam logic [QUOT_W-1:0] UNITY_GAIN = 18'd256;
  localparam logic [QUOT_W-1:0] SAT_GAIN   = 18'h3FFFF;

  localparam logic TAG_B = 1'b0;
  localparam logic TAG_R = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SUM     = 3'd1;
  localparam logic [2:0] ST_ISSUE_B = 3'd2;
  localparam logic [2:0] ST_ISSUE_R = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;

  typedef struct packed {
    logic valid;
    logic id;
    logic zero;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/wb_tag_pipe.sv
// ---------------------------------------------------------------------------
// wb_tag_pipe : DIV_LAT-deep tag shift register tracking divider issues (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module wb_tag_pipe
  import wb_gain_sched_pkg::*;
#(
  parameter int DIV_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DIV_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIV_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DIV_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DIV_LAT-1];

endmodule

`default_nettype wire

// File: rtl/wb_gain_sched.sv
// ---------------------------------------------------------------------------
// wb_gain_sched : white-balance gain sequencer sharing one pipelined divider (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module wb_gain_sched
  import wb_gain_sched_pkg::*;
#(
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AVG_W-1:0]  b_avg,
  input  logic [AVG_W-1:0]  g0_avg,
  input  logic [AVG_W-1:0]  g1_avg,
  input  logic [AVG_W-1:0]  r_avg,
  output logic              div_issue,
  output logic [QUOT_W-1:0] div_numer,
  output logic [DEN_W-1:0]  div_denom,
  input  logic [QUOT_W-1:0] div_quot,
  output logic [QUOT_W-1:0] bk,
  output logic [QUOT_W-1:0] rk,
  output logic              zero_b,
  output logic              zero_r,
  output logic              busy,
  output logic              done
);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [AVG_W-1:0]  b_lat;
  logic [AVG_W-1:0]  g0_lat;
  logic [AVG_W-1:0]  g1_lat;
  logic [AVG_W-1:0]  r_lat;
  logic [SUM_W-1:0]  gsum;
  logic [AVG_W-1:0]  issue_avg;
  logic [QUOT_W-1:0] capture_val;
  tag_t              tag_in;
  tag_t              tag_out;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_SUM;
      ST_SUM:     state_nxt = ST_ISSUE_B;
      ST_ISSUE_B: state_nxt = ST_ISSUE_R;
      ST_ISSUE_R: state_nxt = ST_WAIT;
      ST_WAIT:    if (tag_out.valid && (tag_out.id == TAG_R)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign div_issue = (state == ST_ISSUE_B) || (state == ST_ISSUE_R);
  assign issue_avg = (state == ST_ISSUE_R) ? r_lat : b_lat;
  assign div_numer = div_issue ? {1'b0, gsum, 7'b0} : '0;
  assign div_denom = div_issue ? {2'b0, issue_avg} : '0;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    tag_in = '0;
    if (div_issue) begin
      tag_in.valid = 1'b1;
      tag_in.id    = (state == ST_ISSUE_R) ? TAG_R : TAG_B;
      tag_in.zero  = (issue_avg == '0);
    end
  end

  wb_tag_pipe #(
    .DIV_LAT (DIV_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // A zero denominator never trusts the divider output; it saturates instead.
  assign capture_val = tag_out.zero ? SAT_GAIN : div_quot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      b_lat  <= '0;
      g0_lat <= '0;
      g1_lat <= '0;
      r_lat  <= '0;
      gsum   <= '0;
      bk     <= UNITY_GAIN;
      rk     <= UNITY_GAIN;
      zero_b <= 1'b0;
      zero_r <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if ((state == ST_IDLE) && start) begin
        b_lat  <= b_avg;
        g0_lat <= g0_avg;
        g1_lat <= g1_avg;
        r_lat  <= r_avg;
      end
      if (state == ST_SUM) begin
        gsum <= {2'b0, g0_lat} + {2'b0, g1_lat};
      end
      if (tag_out.valid) begin
        if (tag_out.id == TAG_B) begin
          bk     <= capture_val;
          zero_b <= tag_out.zero;
        end else begin
          rk     <= capture_val;
          zero_r <= tag_out.zero;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_gain_sched.sv
// ---------------------------------------------------------------------------
// tb_wb_gain_sched : scoreboard bench for wb_gain_sched at DIV_LAT 8, 1 and 16 (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_wb_gain_sched;

  typedef struct {
    logic [17:0] bk;
    logic [17:0] rk;
    logic        zb;
    logic        zr;
    int          acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_m;
  logic       start_s;
  logic [7:0] b_avg, g0_avg, g1_avg, r_avg;

  logic        div_issue_a [3];
  logic [17:0] numer_a     [3];
  logic [9:0]  denom_a     [3];
  logic [17:0] quot_a      [3];
  logic [17:0] bk_a        [3];
  logic [17:0] rk_a        [3];
  logic        zb_a        [3];
  logic        zr_a        [3];
  logic        busy_a      [3];
  logic        done_a      [3];

  exp_t  sbq [3][$];
  exp_t  mon_e;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    done_cnt [3] = '{0, 0, 0};
  logic [17:0] dp [3][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_gain_sched #(.DIV_LAT(8)) dut (
    .clk(clk), .rst(rst), .start(start_m),
    .b_avg(b_avg), .g0_avg(g0_avg), .g1_avg(g1_avg), .r_avg(r_avg),
    .div_issue(div_issue_a[0]), .div_numer(numer_a[0]), .div_denom(denom_a[0]),
    .div_quot(quot_a[0]), .bk(bk_a[0]), .rk(rk_a[0]),
    .zero_b(zb_a[0]), .zero_r(zr_a[0]), .busy(busy_a[0]), .done(done_a[0])
  );

  wb_gain_sched #(.DIV_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .start(start_s),
    .b_avg(b_avg), .g0_avg(g0_avg), .g1_avg(g1_avg), .r_avg(r_avg),
    .div_issue(div_issue_a[1]), .div_numer(numer_a[1]), .div_denom(denom_a[1]),
    .div_quot(quot_a[1]), .bk(bk_a[1]), .rk(rk_a[1]),
    .zero_b(zb_a[1]), .zero_r(zr_a[1]), .busy(busy_a[1]), .done(done_a[1])
  );

  wb_gain_sched #(.DIV_LAT(16)) dut_l16 (
    .clk(clk), .rst(rst), .start(start_s),
    .b_avg(b_avg), .g0_avg(g0_avg), .g1_avg(g1_avg), .r_avg(r_avg),
    .div_issue(div_issue_a[2]), .div_numer(numer_a[2]), .div_denom(denom_a[2]),
    .div_quot(quot_a[2]), .bk(bk_a[2]), .rk(rk_a[2]),
    .zero_b(zb_a[2]), .zero_r(zr_a[2]), .busy(busy_a[2]), .done(done_a[2])
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [17:0] div_f(input logic [17:0] n, input logic [9:0] dn);
    if (dn == 10'd0) return 18'h0;
    return 18'(int'(n) / int'(dn));
  endfunction

  function automatic logic [17:0] exp_gain(input logic [7:0] g0, input logic [7:0] g1,
                                           input logic [7:0] a);
    int s;
    s = (int'(g0) + int'(g1)) * 128;
    if (a == 8'd0) return 18'h3FFFF;
    return 18'(s / int'(a));
  endfunction

  // Divider model: idle slots carry a junk value so a mistimed capture is visible.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      dp[d][0] <= div_issue_a[d] ? div_f(numer_a[d], denom_a[d]) : 18'h2AAAA;
      for (int i = 1; i < 16; i++) dp[d][i] <= dp[d][i-1];
    end
  end
  assign quot_a[0] = dp[0][7];
  assign quot_a[1] = dp[1][0];
  assign quot_a[2] = dp[2][15];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (done_a[d] === 1'b1) begin
        done_cnt[d] = done_cnt[d] + 1;
        if (sbq[d].size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done dut%0d cyc=%0d got done=1 want none", d, cyc);
        end else begin
          mon_e = sbq[d].pop_front();
          total++;
          if ((cyc - mon_e.acc) !== (lat_of(d) + 4)) begin
            bad++;
            $display("FAIL latency dut%0d got=%0d want=%0d", d, cyc - mon_e.acc, lat_of(d) + 4);
          end
          total++;
          if (bk_a[d] !== mon_e.bk) begin
            bad++; $display("FAIL bk dut%0d got=%0d want=%0d", d, bk_a[d], mon_e.bk);
          end
          total++;
          if (rk_a[d] !== mon_e.rk) begin
            bad++; $display("FAIL rk dut%0d got=%0d want=%0d", d, rk_a[d], mon_e.rk);
          end
          total++;
          if ({zb_a[d], zr_a[d]} !== {mon_e.zb, mon_e.zr}) begin
            bad++;
            $display("FAIL zero_flags dut%0d got=%b%b want=%b%b", d, zb_a[d], zr_a[d],
                     mon_e.zb, mon_e.zr);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_avgs(input logic [7:0] b, input logic [7:0] g0,
                          input logic [7:0] g1, input logic [7:0] r);
    b_avg = b; g0_avg = g0; g1_avg = g1; r_avg = r;
  endtask

  task automatic push_exp(input int d);
    exp_t e;
    e.bk  = exp_gain(g0_avg, g1_avg, b_avg);
    e.rk  = exp_gain(g0_avg, g1_avg, r_avg);
    e.zb  = (b_avg == 8'd0);
    e.zr  = (r_avg == 8'd0);
    e.acc = cyc;
    sbq[d].push_back(e);
  endtask

  task automatic wait_drain(input int d, input int bound);
    int n;
    n = 0;
    while (sbq[d].size() != 0 && n < bound) begin
      tick();
      n++;
    end
    total++;
    if (sbq[d].size() != 0) begin
      bad++;
      $display("FAIL drain_timeout dut%0d got pending=%0d want 0", d, sbq[d].size());
      sbq[d].delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_m = 1'b0; start_s = 1'b0;
    set_avgs(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) tick();
    total++; if (bk_a[0] !== 18'd256) begin bad++; $display("FAIL rst_bk got=%0d want=256", bk_a[0]); end
    total++; if (rk_a[0] !== 18'd256) begin bad++; $display("FAIL rst_rk got=%0d want=256", rk_a[0]); end
    total++; if ({zb_a[0], zr_a[0]} !== 2'b00) begin bad++; $display("FAIL rst_zero got=%b%b want=00", zb_a[0], zr_a[0]); end
    total++; if (busy_a[0] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_a[0]); end
    total++; if (done_a[0] !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_a[0]); end
    total++; if (div_issue_a[0] !== 1'b0) begin bad++; $display("FAIL rst_issue got=%b want=0", div_issue_a[0]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    set_avgs(8'd64, 8'd64, 8'd64, 8'd128);
    start_m = 1'b1;
    push_exp(0);
    tick();
    start_m = 1'b0;
    set_avgs(8'd3, 8'd7, 8'd9, 8'd5);
    total++; if ({busy_a[0], div_issue_a[0], numer_a[0]} !== {1'b1, 1'b0, 18'd0}) begin
      bad++; $display("FAIL nom_c1 got busy=%b issue=%b numer=%0d want 1 0 0", busy_a[0], div_issue_a[0], numer_a[0]);
    end
    tick();
    total++; if ({div_issue_a[0], numer_a[0], denom_a[0]} !== {1'b1, 18'd16384, 10'd64}) begin
      bad++; $display("FAIL nom_issue_b got issue=%b numer=%0d denom=%0d want 1 16384 64", div_issue_a[0], numer_a[0], denom_a[0]);
    end
    tick();
    total++; if ({div_issue_a[0], numer_a[0], denom_a[0]} !== {1'b1, 18'd16384, 10'd128}) begin
      bad++; $display("FAIL nom_issue_r got issue=%b numer=%0d denom=%0d want 1 16384 128", div_issue_a[0], numer_a[0], denom_a[0]);
    end
    repeat (8) tick();
    total++; if ({bk_a[0], busy_a[0], done_a[0]} !== {18'd256, 1'b1, 1'b0}) begin
      bad++; $display("FAIL nom_c11 got bk=%0d busy=%b done=%b want 256 1 0", bk_a[0], busy_a[0], done_a[0]);
    end
    tick();
    total++; if ({rk_a[0], busy_a[0], done_a[0]} !== {18'd128, 1'b0, 1'b1}) begin
      bad++; $display("FAIL nom_c12 got rk=%0d busy=%b done=%b want 128 0 1", rk_a[0], busy_a[0], done_a[0]);
    end
    wait_drain(0, 5);
  endtask

  task automatic test_zero_denom();
    set_avgs(8'd0, 8'd100, 8'd100, 8'd32);
    start_m = 1'b1;
    push_exp(0);
    tick();
    start_m = 1'b0;
    wait_drain(0, 30);
    tick();
  endtask

  task automatic test_reset_midflight();
    set_avgs(8'd32, 8'd64, 8'd64, 8'd16);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    start_m = 1'b1;
    tick();
    rst = 1'b0;
    start_m = 1'b0;
    total++; if ({bk_a[0], rk_a[0], zb_a[0], zr_a[0], busy_a[0]} !== {18'd256, 18'd256, 3'b000}) begin
      bad++; $display("FAIL midrst_state got bk=%0d rk=%0d zb=%b zr=%b busy=%b want 256 256 0 0 0",
                      bk_a[0], rk_a[0], zb_a[0], zr_a[0], busy_a[0]);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      total++; if ({div_issue_a[0], done_a[0]} !== 2'b00) begin
        bad++; $display("FAIL midrst_quiet k=%0d got issue=%b done=%b want 0 0", k, div_issue_a[0], done_a[0]);
      end
    end
  endtask

  task automatic test_busy_reject();
    int d0;
    d0 = done_cnt[0];
    set_avgs(8'd64, 8'd64, 8'd64, 8'd128);
    start_m = 1'b1;
    push_exp(0);
    tick();
    start_m = 1'b0;
    repeat (4) tick();
    start_m = 1'b1;
    b_avg = 8'd1;
    tick();
    start_m = 1'b0;
    wait_drain(0, 30);
    repeat (15) tick();
    total++; if ((done_cnt[0] - d0) !== 1) begin
      bad++; $display("FAIL busy_done_count got=%0d want=1", done_cnt[0] - d0);
    end
  endtask

  task automatic test_back_to_back();
    int next_acc;
    int pushed;
    start_m = 1'b1;
    next_acc = cyc;
    pushed = 0;
    for (int k = 0; k < 60 && pushed < 3; k++) begin
      set_avgs(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
      if (cyc == next_acc) begin
        push_exp(0);
        pushed++;
        next_acc += 12;
      end
      tick();
    end
    start_m = 1'b0;
    wait_drain(0, 40);
    tick();
  endtask

  task automatic test_sweep();
    set_avgs(8'd64, 8'd64, 8'd64, 8'd128);
    start_s = 1'b1;
    push_exp(1);
    push_exp(2);
    tick();
    start_s = 1'b0;
    wait_drain(1, 30);
    wait_drain(2, 30);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_denom();
    test_reset_midflight();
    test_busy_reject();
    test_back_to_back();
    test_sweep();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/wb_gain_sched.md
# wb_gain_sched

Sequencer for the white-balance gain stage: on each `start` it latches the four Bayer channel averages and forms the green sum. It then time-shares one external pipelined divider between the blue and red gain divisions, tagging each issue so the returning quotients land in the correct register. It sits between the per-channel averagers and the downstream gain multipliers. It replaces hand-built valid shift chains with an explicit FSM and a tag pipeline.

## Interface
- `DIV_LAT`, 8: divider latency in cycles from issue to quotient (≥1).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a gain update; accepted only when `busy`=0.
- `b_avg`, `g0_avg`, `g1_avg`, `r_avg` in 8 each: channel averages, sampled on the accepting edge.
- `div_issue` out 1: numerator/denominator valid to the divider this cycle.
- `div_numer` out 18: `{1'b0, gsum[9:0], 7'b0}`.
- `div_denom` out 10: `{2'b0, avg}`.
- `div_quot` in 18: divider quotient, `DIV_LAT` cycles after its issue.
- `bk`, `rk` out 18: blue/red gains, unsigned, 256 = unity.
- `zero_b`, `zero_r` out 1: last update saw a zero denominator.
- `busy` out 1: an update is in flight.
- `done` out 1: one-cycle pulse, both gains updated.

## Operation
- FSM states: IDLE → SUM → ISSUE_B → ISSUE_R → WAIT → IDLE.
- IDLE: if `start`, latch all four averages and go to SUM.
- SUM: register `gsum = g0 + g1` (10-bit, max 510, no overflow).
- ISSUE_B: `div_issue`=1, denominator is `b`. Push tag {valid, id=B, zero=(b==0)} into the tag pipe.
- ISSUE_R: same as ISSUE_B with `r`, id=R.
- WAIT: hold until the R tag exits the pipe, then go to IDLE.
- Tag pipe: `DIV_LAT` stages. The exiting tag selects the capture register.
- Capture: if `zero` is set, write `18'h3FFFF` (saturated), else write `div_quot`. The matching `zero_b`/`zero_r` flag is updated on the same edge.
- `done` is registered high on the edge that captures R.
- `div_numer`/`div_denom` are 0 when `div_issue`=0.
- `start` while `busy` is ignored; no queueing.
- Averages may change after acceptance without effect.
- `gsum`=0 with a nonzero denominator gives quotient 0 (the divider result is used as is).

## Timing
- Reset values: `bk`=`rk`=256, `zero_b`=`zero_r`=0, `busy`=0, `done`=0, `div_issue`=0, FSM in IDLE, all tags cleared.
- Cycle numbering: start accepted at the end of cycle 0.
  - Cycle 1: SUM.
  - Cycle 2: B issue.
  - Cycle 3: R issue.
  - `bk` visible from cycle 3+DIV_LAT.
  - `rk` and `done` visible in cycle 4+DIV_LAT.
  - Total latency is DIV_LAT+4 cycles.
- `busy` is high from cycle 1 through cycle 3+DIV_LAT inclusive. It is low in the `done` cycle.
- A `start` in the `done` cycle is accepted. Back-to-back throughput is one update per DIV_LAT+4 cycles.
- `rst` mid-operation: the FSM returns to IDLE and the tag pipe is flushed. Gains and flags go to their reset values, and no `done` follows. In-flight quotients are discarded.
- Simultaneous `rst` and `start`: `rst` wins.

## Structure
- Shared package contents:
  - FSM state encoding.
  - `UNITY_GAIN`=18'd256.
  - `SAT_GAIN`=18'h3FFFF.
  - Tag id constants (B, R).
  - Width constants: 8 for averages, 10 for the sum, 18 for the numerator and quotient.
- One sub-module, `wb_tag_pipe`:
  - A `DIV_LAT`-deep shift register of {valid, id, zero}.
  - Synchronous clear on `rst`.
- The top level holds the FSM, the input latches, `gsum` and the capture logic.

## Test plan
- Nominal: b=64, g0=g1=64, r=128, start, DIV_LAT=8, divider model.
  - Numerators are 16384.
  - Cycle 11: `bk`=256.
  - Cycle 12: `rk`=128 and `done`=1.
- Zero denominator: b=0, r=32, g0=g1=100.
  - `bk`=0x3FFFF, `zero_b`=1.
  - `rk`=(200·128)/32=800, `zero_r`=0.
- Busy rejection: second start at cycle 5 with b=1.
  - Ignored; `bk` reflects the first inputs only.
  - Exactly one `done` pulse.
- Back-to-back: start held high continuously.
  - `done` pulses every 12 cycles.
  - Each result matches the inputs sampled at its own acceptance edge.
- Reset mid-flight: `rst` at cycle 6.
  - `bk`=`rk`=256, `busy`=0.
  - No `done` within the next 20 cycles.
  - `div_issue` stays 0 until the next start.
- Parameter sweep: DIV_LAT=1 and DIV_LAT=16 with the nominal inputs.
  - `done` appears at cycle 5 and cycle 20 respectively.
  - Gains are identical to the nominal case.
